// File: rtl/nios_mtl_mem_arbiter_if.sv
// Avalon-MM style requester port shared by the Nios data master and the render fetch engine.
// The master modport is the requester side and the slave modport is the arbiter side.
interface nios_mtl_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_mtl_mem_arbiter.sv
// Round-robin arbiter sharing the single-port program/data memory between m0 (Nios) and m1 (render fetch).
// Fixed one-cycle read return tagged to the issuing requester; out-of-range accesses are trapped.
module nios_mtl_mem_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 5000
) (
  input  logic                clk,
  input  logic                reset,
  nios_mtl_mem_arbiter_if.slave m0,
  nios_mtl_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken,
  output logic                err_flag,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_src,
  input  logic                err_clear
);

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic                req0, req1;
  logic                gnt0, gnt1;
  logic                acc;
  logic                in_range;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wd;
  logic                sel_wr;
  logic [DATA_W-1:0]   rd_data;

  logic rr_last;   // 1 = m1 granted most recently
  logic rd_pend;
  logic rd_owner;
  logic rd_oor;

  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || rr_last)) gnt0 = 1'b1;
      else if (req1)                  gnt1 = 1'b1;
    end
    acc      = gnt0 | gnt1;
    sel_addr = gnt1 ? m1.address    : m0.address;
    sel_be   = gnt1 ? m1.byteenable : m0.byteenable;
    sel_wd   = gnt1 ? m1.writedata  : m0.writedata;
    sel_wr   = gnt1 ? m1.write      : m0.write;
    in_range = {1'b0, sel_addr} < DEPTH_LIM;
    rd_data  = rd_oor ? '0 : mem_readdata;
  end

  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wd;
  assign mem_chipselect = acc & in_range;
  assign mem_write      = acc & in_range & sel_wr;
  assign mem_clken      = ~reset;

  assign m0.waitrequest   = reset | (req0 & ~gnt0);
  assign m1.waitrequest   = reset | (req1 & ~gnt1);
  assign m0.readdata      = rd_data;
  assign m1.readdata      = rd_data;
  assign m0.readdatavalid = rd_pend & ~rd_owner;
  assign m1.readdatavalid = rd_pend &  rd_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last  <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
      err_flag <= 1'b0;
      err_addr <= '0;
      err_src  <= 1'b0;
    end else begin
      if (acc) rr_last <= gnt1;
      rd_pend  <= acc & ~sel_wr;
      rd_owner <= gnt1;
      rd_oor   <= ~in_range;
      // A clear in the same cycle as a new error drops that error entirely.
      if (err_clear) begin
        err_flag <= 1'b0;
        err_addr <= '0;
        err_src  <= 1'b0;
      end else if (acc && !in_range && !err_flag) begin
        err_flag <= 1'b1;
        err_addr <= sel_addr;
        err_src  <= gnt1;
      end
    end
  end

endmodule

// File: tb/tb_nios_mtl_mem_arbiter.sv
// Randomized bench for nios_mtl_mem_arbiter with directed scenarios and a
// transaction-level reference model (shadow memory, turn bit, expected returns).
module tb_nios_mtl_mem_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clear = 1'b0;
  always #5 clk = ~clk;

  nios_mtl_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  nios_mtl_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_flag, err_src;
  logic [12:0] err_addr;

  nios_mtl_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .err_flag(err_flag), .err_addr(err_addr),
    .err_src(err_src), .err_clear(err_clear)
  );

  // Physical memory: address registered at the edge, output combinational from it.
  logic [31:0] init_mem [DEPTH];
  logic [31:0] phys [DEPTH];
  logic [12:0] phys_ra = '0;
  logic        load = 1'b1;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) phys[i] <= init_mem[i];
    end else if (mem_clken && mem_chipselect) begin
      for (int i = 0; i < 4; i++)
        if (mem_write && mem_byteenable[i]) phys[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      phys_ra <= mem_address;
    end
  end
  assign mem_readdata = (int'(phys_ra) < DEPTH) ? phys[phys_ra] : 32'hBAD0_BAD0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          m_m0_turn;      // on contention, m0 wins when set
  bit          m_v0, m_v1;
  logic [31:0] m_rd;
  bit          m_ef, m_es;
  logic [12:0] m_ea;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rd0, last_rd1;
  bit obs_w0, obs_w1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int port, input bit rd, input bit wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    if (port == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.byteenable = be; m0_bus.writedata = wd;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.byteenable = be; m1_bus.writedata = wd;
    end
  endtask

  task automatic rand_cmd(input int port);
    int k;
    logic [12:0] a;
    k = $urandom_range(0, 9);
    if ($urandom_range(0, 9) == 0) a = 13'($urandom_range(DEPTH, 8191));
    else                           a = 13'($urandom_range(0, 47));
    set_cmd(port, ((k >= 3) && (k <= 6)) || (k == 9), k >= 7, a, 4'($urandom), $urandom);
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit r0, r1, g0, g1, wr, inr;
    logic [12:0] a;
    logic [31:0] wd, cur;
    logic [3:0]  be;
    @(negedge clk);
    obs_w0 = m0_bus.waitrequest;
    obs_w1 = m1_bus.waitrequest;
    if (reset) begin
      check("rst_m0_wait", m0_bus.waitrequest, 1);
      check("rst_m1_wait", m1_bus.waitrequest, 1);
      check("rst_cs", mem_chipselect, 0);
      check("rst_clken", mem_clken, 0);
      check("rst_m0_rdv", m0_bus.readdatavalid, 0);
      check("rst_m1_rdv", m1_bus.readdatavalid, 0);
      check("rst_err_flag", err_flag, 0);
      @(posedge clk);
      m_m0_turn = 1; m_v0 = 0; m_v1 = 0; m_ef = 0; m_ea = '0; m_es = 0;
      #1;
      return;
    end
    r0 = m0_bus.read || m0_bus.write;
    r1 = m1_bus.read || m1_bus.write;
    check("m0_rdv", m0_bus.readdatavalid, m_v0);
    check("m1_rdv", m1_bus.readdatavalid, m_v1);
    if (m_v0) begin check("m0_rdata", m0_bus.readdata, m_rd); last_rd0 = m0_bus.readdata; end
    if (m_v1) begin check("m1_rdata", m1_bus.readdata, m_rd); last_rd1 = m1_bus.readdata; end
    g0 = (r0 && r1) ? m_m0_turn : r0;
    g1 = r1 && !g0;
    check("m0_wait", m0_bus.waitrequest, r0 && !g0);
    check("m1_wait", m1_bus.waitrequest, r1 && !g1);
    a   = g1 ? m1_bus.address    : m0_bus.address;
    wr  = g1 ? m1_bus.write      : m0_bus.write;
    be  = g1 ? m1_bus.byteenable : m0_bus.byteenable;
    wd  = g1 ? m1_bus.writedata  : m0_bus.writedata;
    inr = int'(a) < DEPTH;
    check("mem_cs", mem_chipselect, (g0 || g1) && inr);
    check("mem_clken", mem_clken, 1);
    if ((g0 || g1) && inr) begin
      check("mem_addr", mem_address, a);
      check("mem_we", mem_write, wr);
      if (wr) begin
        check("mem_be", mem_byteenable, be);
        check("mem_wd", mem_writedata, wd);
      end
    end
    check("err_flag", err_flag, m_ef);
    if (m_ef) begin
      check("err_addr", err_addr, m_ea);
      check("err_src", err_src, m_es);
    end
    @(posedge clk);
    m_v0 = g0 && !wr;
    m_v1 = g1 && !wr;
    m_rd = inr ? ref_mem[a] : 32'h0;
    if ((g0 || g1) && wr && inr) begin
      cur = ref_mem[a];
      for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
      ref_mem[a] = cur;
    end
    if (g0 || g1) m_m0_turn = g1;
    if (err_clear) begin
      m_ef = 0; m_ea = '0; m_es = 0;
    end else if ((g0 || g1) && !inr && !m_ef) begin
      m_ef = 1; m_ea = a; m_es = g1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) init_mem[i] = $urandom;
    init_mem[16]  = 32'hDEADBEEF;
    init_mem[256] = 32'hAABBCCDD;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_mem[i];
    set_cmd(0, 0, 0, '0, '0, '0);
    set_cmd(1, 0, 0, '0, '0, '0);
    m_m0_turn = 1; m_v0 = 0; m_v1 = 0; m_ef = 0; m_ea = '0; m_es = 0; m_rd = '0;
    last_rd0 = '0; last_rd1 = '0;

    step(); step();
    load = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Single read of a known word
    set_cmd(0, 1, 0, 13'h0010, 4'hF, '0);
    step();
    check("t1_m0_wait", obs_w0, 0);
    set_cmd(0, 0, 0, '0, '0, '0);
    step();
    check("t1_data", last_rd0, 32'hDEADBEEF);

    // Continuous contention
    set_cmd(0, 1, 0, 13'd20, 4'hF, '0);
    set_cmd(1, 1, 0, 13'd21, 4'hF, '0);
    for (int i = 0; i < 6; i++) step();
    set_cmd(0, 0, 0, '0, '0, '0);
    set_cmd(1, 0, 0, '0, '0, '0);
    step();

    // Byte-lane write then readback
    set_cmd(1, 0, 1, 13'h0100, 4'b0101, 32'h11223344);
    step();
    set_cmd(1, 1, 0, 13'h0100, 4'hF, '0);
    step();
    set_cmd(1, 0, 0, '0, '0, '0);
    step();
    check("t3_bytewrite", last_rd1, 32'hAA22CC44);

    // Out-of-range trap, capture and clear
    last_rd1 = 32'hFFFFFFFF;
    set_cmd(0, 0, 1, 13'd5000, 4'hF, 32'h12345678);
    step();
    set_cmd(0, 0, 0, '0, '0, '0);
    set_cmd(1, 1, 0, 13'd6000, 4'hF, '0);
    step();
    set_cmd(1, 0, 0, '0, '0, '0);
    step();
    check("t4_oor_rdata", last_rd1, 32'h0);
    check("t4_err_flag", err_flag, 1);
    check("t4_err_addr", err_addr, 13'd5000);
    check("t4_err_src", err_src, 0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    check("t4_clr_flag", err_flag, 0);
    check("t4_clr_addr", err_addr, 0);
    err_clear = 1'b1;
    set_cmd(0, 0, 1, 13'd7000, 4'hF, '0);
    step();
    err_clear = 1'b0;
    set_cmd(0, 0, 0, '0, '0, '0);
    step();
    check("t4_clear_wins", err_flag, 0);

    // Reset right after a read accept, requests held through reset
    set_cmd(0, 1, 0, 13'h0010, 4'hF, '0);
    step();
    reset = 1'b1;
    set_cmd(1, 1, 0, 13'd30, 4'hF, '0);
    step(); step();
    reset = 1'b0;
    step();
    check("t5_m0_first", obs_w0, 0);
    check("t5_m1_waits", obs_w1, 1);
    set_cmd(0, 0, 0, '0, '0, '0);
    set_cmd(1, 0, 0, '0, '0, '0);
    step();

    // Randomized traffic with requests held until accepted
    rand_cmd(0);
    rand_cmd(1);
    for (int c = 0; c < 3000; c++) begin
      err_clear = ($urandom_range(0, 49) == 0);
      step();
      if (!obs_w0) rand_cmd(0);
      if (!obs_w1) rand_cmd(1);
    end
    err_clear = 1'b0;
    set_cmd(0, 0, 0, '0, '0, '0);
    set_cmd(1, 0, 0, '0, '0, '0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
